// File: rtl/decode_pkg.sv
// Shared decode definitions: class encodings, opcode constants and the
// decoded-entry layout at the default widths.
package decode_pkg;

  typedef enum logic [2:0] {
    CLS_LDI     = 3'd0,
    CLS_MOV     = 3'd1,
    CLS_LDM     = 3'd2,
    CLS_STM     = 3'd3,
    CLS_ALU     = 3'd4,
    CLS_ILLEGAL = 3'd7
  } cls_e;

  localparam int unsigned OP_LDI       = 0;
  localparam int unsigned OP_MOV       = 1;
  localparam int unsigned OP_LDM       = 2;
  localparam int unsigned OP_STM       = 3;
  localparam int unsigned OP_ALU_FIRST = 4;

  localparam int unsigned DEF_OPC_W  = 6;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_IMM_W  = 16;

  typedef struct packed {
    logic [DEF_OPC_W-1:0]  op;
    logic [2:0]            cls;
    logic [DEF_REG_W-1:0]  rdst2;
    logic [DEF_REG_W-1:0]  rdst1;
    logic [DEF_REG_W-1:0]  rsrc2;
    logic [DEF_REG_W-1:0]  rsrc1;
    logic [DEF_ADDR_W-1:0] rdst_add;
    logic [DEF_ADDR_W-1:0] rsrc_add;
    logic [DEF_IMM_W-1:0]  imm;
    logic                  illegal;
  } decode_entry_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction splitter: word -> opcode, class and fields.
// Fields not used by the decoded class are forced to zero.
module decode_fields
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned ALU_LAST = 16
) (
  input  logic [INSTR_W-1:0] code,
  output logic [OPC_W-1:0]   op,
  output logic [2:0]         cls,
  output logic [REG_W-1:0]   rdst2,
  output logic [REG_W-1:0]   rdst1,
  output logic [REG_W-1:0]   rsrc2,
  output logic [REG_W-1:0]   rsrc1,
  output logic [ADDR_W-1:0]  rdst_add,
  output logic [ADDR_W-1:0]  rsrc_add,
  output logic [IMM_W-1:0]   imm,
  output logic               illegal
);

  localparam int unsigned T = INSTR_W - OPC_W - 1;

  int unsigned opn;

  always_comb begin
    op       = code[INSTR_W-1 -: OPC_W];
    opn      = 32'(op);
    cls      = CLS_ILLEGAL;
    illegal  = 1'b0;
    rdst2    = '0;
    rdst1    = '0;
    rsrc2    = '0;
    rsrc1    = '0;
    rdst_add = '0;
    rsrc_add = '0;
    imm      = '0;
    if (opn == OP_LDI) begin
      cls   = CLS_LDI;
      rdst2 = code[T -: REG_W];
      imm   = code[IMM_W-1:0];
    end else if (opn == OP_MOV) begin
      cls   = CLS_MOV;
      rdst2 = code[T -: REG_W];
      rsrc2 = code[REG_W-1:0];
    end else if (opn == OP_LDM) begin
      cls      = CLS_LDM;
      rdst2    = code[T -: REG_W];
      rsrc_add = code[ADDR_W-1:0];
    end else if (opn == OP_STM) begin
      cls      = CLS_STM;
      rdst_add = code[T -: ADDR_W];
      rsrc2    = code[REG_W-1:0];
    end else if (opn >= OP_ALU_FIRST && opn <= ALU_LAST) begin
      cls   = CLS_ALU;
      rdst2 = code[T -: REG_W];
      rdst1 = code[T-REG_W -: REG_W];
      rsrc2 = code[2*REG_W-1:REG_W];
      rsrc1 = code[REG_W-1:0];
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, 2-entry skid buffer and flush.
// Optional delivery statistics are enabled by defining DECODE_STATS_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned OPC_W    = 6,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned ALU_LAST = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   op,
  output logic [2:0]         cls,
  output logic [REG_W-1:0]   rdst2,
  output logic [REG_W-1:0]   rdst1,
  output logic [REG_W-1:0]   rsrc2,
  output logic [REG_W-1:0]   rsrc1,
  output logic [ADDR_W-1:0]  rsrc_add,
  output logic [ADDR_W-1:0]  rdst_add,
  output logic [IMM_W-1:0]   imm,
  output logic               illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]        stat_insn,
  output logic [15:0]        stat_illegal
`endif
);

  typedef struct packed {
    logic [OPC_W-1:0]  op;
    logic [2:0]        cls;
    logic [REG_W-1:0]  rdst2;
    logic [REG_W-1:0]  rdst1;
    logic [REG_W-1:0]  rsrc2;
    logic [REG_W-1:0]  rsrc1;
    logic [ADDR_W-1:0] rdst_add;
    logic [ADDR_W-1:0] rsrc_add;
    logic [IMM_W-1:0]  imm;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e state;
  entry_t dec, main_q, skid_q;
  logic   in_ready_q;
  logic   accept;

  decode_fields #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .REG_W   (REG_W),
    .ADDR_W  (ADDR_W),
    .IMM_W   (IMM_W),
    .ALU_LAST(ALU_LAST)
  ) u_fields (
    .code    (code),
    .op      (dec.op),
    .cls     (dec.cls),
    .rdst2   (dec.rdst2),
    .rdst1   (dec.rdst1),
    .rsrc2   (dec.rsrc2),
    .rsrc1   (dec.rsrc1),
    .rdst_add(dec.rdst_add),
    .rsrc_add(dec.rsrc_add),
    .imm     (dec.imm),
    .illegal (dec.illegal)
  );

  assign accept = in_valid & in_ready_q;

  // Flush shares the reset path: both empty the stage and drop any word offered this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q <= dec;
          state  <= ONE;
        end
        ONE: begin
          if (accept && out_ready) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (out_ready) begin
            main_q <= '0;
            state  <= EMPTY;
          end
        end
        FULL: if (out_ready) begin
          main_q     <= skid_q;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
          state      <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state != EMPTY);
  assign in_ready  = in_ready_q;
  assign op        = main_q.op;
  assign cls       = main_q.cls;
  assign rdst2     = main_q.rdst2;
  assign rdst1     = main_q.rdst1;
  assign rsrc2     = main_q.rsrc2;
  assign rsrc1     = main_q.rsrc1;
  assign rdst_add  = main_q.rdst_add;
  assign rsrc_add  = main_q.rsrc_add;
  assign imm       = main_q.imm;
  assign illegal   = main_q.illegal;

`ifdef DECODE_STATS_EN
  // A handshake coinciding with flush is not a delivery.
  logic delivered;
  assign delivered = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_insn    <= '0;
      stat_illegal <= '0;
    end else if (delivered) begin
      if (stat_insn != '1) stat_insn <= stat_insn + 32'd1;
      if (main_q.illegal && stat_illegal != '1) stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule
